// File: rtl/popcount_scheduler.sv
// Round-robin front end that time-shares one bit_population_counter engine among
// CHANNELS requesters, tagging each launch so the returned count reaches its owner.
module popcount_scheduler #(
    parameter int WIDTH    = 24,
    parameter int CHANNELS = 4,
    parameter int LATENCY  = 3
) (
    input  logic                        clk_i,
    input  logic                        srst_i,
    input  logic                        en_i,
    input  logic [CHANNELS*WIDTH-1:0]   req_data_i,
    input  logic [CHANNELS-1:0]         req_val_i,
    output logic [CHANNELS-1:0]         req_ready_o,
    output logic [WIDTH-1:0]            cnt_data_o,
    output logic                        cnt_data_val_o,
    input  logic [$clog2(WIDTH)-1:0]    cnt_data_i,
    input  logic                        cnt_data_val_i,
    output logic [$clog2(WIDTH)-1:0]    res_data_o,
    output logic [CHANNELS-1:0]         res_val_o,
    output logic                        busy_o,
    output logic                        err_o
);

    localparam int IW = $clog2(CHANNELS);

    logic [IW-1:0]      rr;
    logic               grant_valid;
    logic [IW-1:0]      grant_id;
    int unsigned        arb_idx;

    logic [IW-1:0]      launch_id;
    logic [LATENCY-1:0] tag_v;
    logic [IW-1:0]      tag_id [LATENCY];
    logic               tail_v;
    logic [IW-1:0]      tail_id;

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        req_ready_o = '0;
        arb_idx     = 0;
        if (en_i && !srst_i) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                arb_idx = (int'(rr) + i) % CHANNELS;
                if (!grant_valid && req_val_i[arb_idx]) begin
                    grant_valid = 1'b1;
                    grant_id    = IW'(arb_idx);
                end
            end
        end
        if (grant_valid) begin
            req_ready_o = CHANNELS'(1) << grant_id;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_data_o     <= '0;
            cnt_data_val_o <= 1'b0;
            launch_id      <= '0;
            rr             <= '0;
        end else begin
            cnt_data_val_o <= grant_valid;
            if (grant_valid) begin
                cnt_data_o <= req_data_i[int'(grant_id)*WIDTH +: WIDTH];
                launch_id  <= grant_id;
                rr         <= IW'((int'(grant_id) + 1) % CHANNELS);
            end
        end
    end

    // Stage 0 is fed from the launch register rather than the grant, so the tail
    // stage lines up with the cycle the engine presents its result.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            tag_v <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_v[0]  <= cnt_data_val_o;
            tag_id[0] <= launch_id;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign tail_v  = tag_v[LATENCY-1];
    assign tail_id = tag_id[LATENCY-1];

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            res_data_o <= '0;
            res_val_o  <= '0;
            err_o      <= 1'b0;
        end else begin
            res_val_o <= '0;
            if (cnt_data_val_i && tail_v) begin
                res_data_o <= cnt_data_i;
                res_val_o  <= CHANNELS'(1) << tail_id;
            end
            if (cnt_data_val_i != tail_v) begin
                err_o <= 1'b1;
            end
        end
    end

    assign busy_o = cnt_data_val_o | (|tag_v);

endmodule

// File: tb/tb_popcount_scheduler.sv
// Bench for popcount_scheduler: stand-in engine, cycle-indexed expectation tables
// derived from the arbitration/return rules, directed scenarios and random traffic.
module tb_popcount_scheduler;
    localparam int WIDTH    = 24;
    localparam int CHANNELS = 4;
    localparam int LATENCY  = 3;
    localparam int CW       = $clog2(WIDTH);
    localparam int NCYC     = 4096;

    logic                      clk_i = 1'b0;
    logic                      srst_i = 1'b1;
    logic                      en_i = 1'b0;
    logic [CHANNELS*WIDTH-1:0] req_data_i = '0;
    logic [CHANNELS-1:0]       req_val_i = '0;
    logic [CHANNELS-1:0]       req_ready_o;
    logic [WIDTH-1:0]          cnt_data_o;
    logic                      cnt_data_val_o;
    logic [CW-1:0]             cnt_data_i;
    logic                      cnt_data_val_i;
    logic [CW-1:0]             res_data_o;
    logic [CHANNELS-1:0]       res_val_o;
    logic                      busy_o;
    logic                      err_o;
    logic                      inject = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    popcount_scheduler #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .LATENCY(LATENCY)) dut (
        .clk_i(clk_i), .srst_i(srst_i), .en_i(en_i),
        .req_data_i(req_data_i), .req_val_i(req_val_i), .req_ready_o(req_ready_o),
        .cnt_data_o(cnt_data_o), .cnt_data_val_o(cnt_data_val_o),
        .cnt_data_i(cnt_data_i), .cnt_data_val_i(cnt_data_val_i),
        .res_data_o(res_data_o), .res_val_o(res_val_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    // Stand-in engine: popcount with LATENCY cycles from data_val_i to data_val_o.
    logic [LATENCY-1:0] eng_v;
    logic [CW-1:0]      eng_d [LATENCY];
    always @(posedge clk_i) begin
        if (srst_i) begin
            eng_v <= '0;
            for (int i = 0; i < LATENCY; i++) eng_d[i] <= '0;
        end else begin
            eng_v[0] <= cnt_data_val_o;
            eng_d[0] <= CW'($countones(cnt_data_o));
            for (int i = 1; i < LATENCY; i++) begin
                eng_v[i] <= eng_v[i-1];
                eng_d[i] <= eng_d[i-1];
            end
        end
    end
    assign cnt_data_val_i = eng_v[LATENCY-1] | inject;
    assign cnt_data_i     = eng_d[LATENCY-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CHANNELS-1:0] arb(input int rr, input logic [CHANNELS-1:0] v,
                                                input logic en, input logic rst);
        if (!en || rst) return '0;
        for (int i = 0; i < CHANNELS; i++) begin
            int c = (rr + i) % CHANNELS;
            if (v[c]) return CHANNELS'(1) << c;
        end
        return '0;
    endfunction

    // Expectation tables indexed by absolute cycle number.
    bit                  exp_cval  [NCYC];
    logic [WIDTH-1:0]    exp_cword [NCYC];
    bit [CHANNELS-1:0]   exp_rv    [NCYC];
    logic [CW-1:0]       exp_rd    [NCYC];
    bit                  exp_busy  [NCYC];
    bit                  exp_tail  [NCYC];

    int                  cyc = 0;
    int                  rr_m = 0;
    bit                  armed = 1'b0;
    bit                  err_m = 1'b0;
    logic [WIDTH-1:0]    cur_cword = '0;
    logic [CW-1:0]       cur_rd = '0;
    logic [CHANNELS-1:0] g_last = '0;

    always @(negedge clk_i) begin
        logic [CHANNELS-1:0] exp_ready;
        logic [WIDTH-1:0]    word;
        int                  id;
        if (cyc + LATENCY + 4 >= NCYC) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", cyc, NCYC - LATENCY - 4);
            $fatal(1, "cycle table exhausted");
        end
        exp_ready = arb(rr_m, req_val_i, en_i, srst_i);
        if (armed) begin
            if (exp_cval[cyc]) cur_cword = exp_cword[cyc];
            if (exp_rv[cyc] != '0) cur_rd = exp_rd[cyc];
            chk("req_ready", req_ready_o, exp_ready);
            chk("cnt_data_val", cnt_data_val_o, exp_cval[cyc]);
            chk("cnt_data", cnt_data_o, cur_cword);
            chk("res_val", res_val_o, exp_rv[cyc]);
            chk("res_data", res_data_o, cur_rd);
            chk("busy", busy_o, exp_busy[cyc]);
            chk("err", err_o, err_m);
        end
        g_last = exp_ready;
        if (srst_i) begin
            for (int k = 1; k <= LATENCY + 3; k++) begin
                exp_cval[cyc+k] = 1'b0;
                exp_rv[cyc+k]   = '0;
                exp_busy[cyc+k] = 1'b0;
                exp_tail[cyc+k] = 1'b0;
            end
            rr_m = 0; err_m = 1'b0; cur_rd = '0; cur_cword = '0; armed = 1'b1;
        end else begin
            if (inject && !exp_tail[cyc]) err_m = 1'b1;
            if (exp_ready != '0) begin
                id = 0;
                for (int c = 0; c < CHANNELS; c++) if (exp_ready[c]) id = c;
                word = req_data_i[id*WIDTH +: WIDTH];
                exp_cval[cyc+1]  = 1'b1;
                exp_cword[cyc+1] = word;
                for (int k = 1; k <= LATENCY + 1; k++) exp_busy[cyc+k] = 1'b1;
                exp_tail[cyc+1+LATENCY] = 1'b1;
                exp_rv[cyc+2+LATENCY]   = CHANNELS'(1) << id;
                exp_rd[cyc+2+LATENCY]   = CW'($countones(word));
                rr_m = (id + 1) % CHANNELS;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        step();
        srst_i = 1'b1; req_val_i = '0; inject = 1'b0; en_i = 1'b0;
        step();
        srst_i = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        srst_i = 1'b0;
        at_neg();
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_resval", res_val_o, '0);

        // single request on ch2
        step();
        en_i = 1'b1; req_val_i = 4'b0100;
        req_data_i[2*WIDTH +: WIDTH] = 24'hFF_0F01;
        at_neg();
        chk("single_ready", req_ready_o, 4'b0100);
        step();
        req_val_i = '0;
        at_neg();
        chk("single_launch", cnt_data_val_o, 1'b1);
        chk("single_word", cnt_data_o, 24'hFF_0F01);
        repeat (4) at_neg();
        chk("single_resval", res_val_o, 4'b0100);
        chk("single_count", res_data_o, 13);

        // all channels continuously valid, word c has c+1 ones
        do_reset();
        en_i = 1'b1; req_val_i = '1;
        for (int c = 0; c < CHANNELS; c++) req_data_i[c*WIDTH +: WIDTH] = WIDTH'((1 << (c + 1)) - 1);
        at_neg();
        chk("rot_g0", req_ready_o, 4'b0001);
        step();
        at_neg();
        chk("rot_g1", req_ready_o, 4'b0010);
        repeat (4) at_neg();
        chk("rot_r0", res_val_o, 4'b0001);
        chk("rot_c0", res_data_o, 1);
        at_neg();
        chk("rot_r1", res_val_o, 4'b0010);
        chk("rot_c1", res_data_o, 2);
        repeat (10) step();
        req_val_i = '0;
        repeat (8) step();

        // fairness starting from rr=2
        do_reset();
        en_i = 1'b1; req_val_i = 4'b0010;
        req_data_i[1*WIDTH +: WIDTH] = 24'h00_0007;
        at_neg();
        chk("fair_pre", req_ready_o, 4'b0010);
        step();
        req_val_i = 4'b1010;
        req_data_i[3*WIDTH +: WIDTH] = 24'hF0_0000;
        at_neg();
        chk("fair_g3a", req_ready_o, 4'b1000);
        step();
        at_neg();
        chk("fair_g1", req_ready_o, 4'b0010);
        step();
        at_neg();
        chk("fair_g3b", req_ready_o, 4'b1000);
        step();
        req_val_i = '0;
        repeat (8) step();

        // en_i drop after three launches
        do_reset();
        en_i = 1'b1; req_val_i = 4'b0001;
        req_data_i[0 +: WIDTH] = 24'hAAAAAA;
        step();
        step();
        step();
        en_i = 1'b0;
        at_neg();
        chk("endrop_ready", req_ready_o, 4'b0000);
        repeat (5) step();
        at_neg();
        chk("endrop_busy", busy_o, 1'b0);
        step();
        en_i = 1'b1;
        at_neg();
        chk("endrop_regrant", req_ready_o, 4'b0001);
        step();
        req_val_i = '0;
        repeat (8) step();

        // stray engine valid with empty tag pipeline
        do_reset();
        repeat (2) step();
        inject = 1'b1;
        step();
        inject = 1'b0;
        at_neg();
        chk("mm_err", err_o, 1'b1);
        chk("mm_resval", res_val_o, '0);
        repeat (3) step();
        at_neg();
        chk("mm_sticky", err_o, 1'b1);
        do_reset();
        at_neg();
        chk("mm_cleared", err_o, 1'b0);

        // reset with two words in flight
        do_reset();
        en_i = 1'b1; req_val_i = 4'b0011;
        req_data_i[0 +: WIDTH] = 24'h123456;
        req_data_i[1*WIDTH +: WIDTH] = 24'h0F0F0F;
        step();
        step();
        req_val_i = '0; srst_i = 1'b1;
        step();
        srst_i = 1'b0;
        at_neg();
        chk("rst_busy", busy_o, 1'b0);
        step();
        req_val_i = 4'b1000;
        req_data_i[3*WIDTH +: WIDTH] = 24'hFFFFFF;
        at_neg();
        chk("rst_g3", req_ready_o, 4'b1000);
        step();
        req_val_i = '0;
        repeat (8) step();

        // random traffic with holding requesters
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            step();
            for (int c = 0; c < CHANNELS; c++) begin
                if (req_val_i[c] && g_last[c]) begin
                    if ($urandom_range(0, 2) == 0) req_val_i[c] = 1'b0;
                    else req_data_i[c*WIDTH +: WIDTH] = WIDTH'($urandom);
                end else if (!req_val_i[c] && $urandom_range(0, 1) == 1) begin
                    req_val_i[c] = 1'b1;
                    req_data_i[c*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
            end
            en_i   = ($urandom_range(0, 9) != 0);
            srst_i = ($urandom_range(0, 199) == 0);
            inject = ($urandom_range(0, 299) == 0);
        end
        step();
        srst_i = 1'b0; inject = 1'b0; req_val_i = '0;
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
